// File: rtl/seq1011_detector.sv
`default_nettype none
// ============================================================================
// Module   : seq1011_detector
// Purpose  : Moore FSM that watches a qualified serial bit stream and flags
//            every occurrence of the pattern 1011, with overlapping matches.
//            Each detection raises a one-cycle match pulse and bumps a
//            saturating match counter.
// Ports    : clk       - single clock, rising-edge active
//            rst       - synchronous active-high reset, highest priority
//            en        - din valid; din only sampled when en=1
//            din       - serial data bit from the upstream flip-flop Q
//            clr_cnt   - synchronous clear of match_cnt / cnt_sat
//            match     - registered one-cycle pulse per detected 1011
//            match_cnt - saturating count of matches since reset/clear
//            cnt_sat   - high while match_cnt is all-ones
//            state_o   - current FSM state (debug)
// Revision : 1.0 - initial release
// ============================================================================
module seq1011_detector #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             din,
    input  logic             clr_cnt,
    output logic             match,
    output logic [CNT_W-1:0] match_cnt,
    output logic             cnt_sat,
    output logic [2:0]       state_o
);

    // State codes are visible on state_o, so they are fixed values.
    localparam logic [2:0] c_s0    = 3'd0;
    localparam logic [2:0] c_s1    = 3'd1;
    localparam logic [2:0] c_s10   = 3'd2;
    localparam logic [2:0] c_s101  = 3'd3;
    localparam logic [2:0] c_s1011 = 3'd4;

    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [2:0]       r_state;
    logic             r_match;
    logic [CNT_W-1:0] r_match_cnt;
    logic             r_cnt_sat;

    logic [2:0]       w_next_state;
    logic             w_illegal;
    logic             w_hit;
    logic [CNT_W-1:0] w_cnt_next;

    // Codes 5..7 are unreachable in normal operation; they fall back to S0.
    assign w_illegal = (r_state > c_s1011);

    always_comb begin
        w_next_state = c_s0;
        case (r_state)
            c_s0:    w_next_state = din ? c_s1    : c_s0;
            c_s1:    w_next_state = din ? c_s1    : c_s10;
            c_s10:   w_next_state = din ? c_s101  : c_s0;
            c_s101:  w_next_state = din ? c_s1011 : c_s10;
            // After a match the trailing 1 is kept as the start of the next one.
            c_s1011: w_next_state = din ? c_s1    : c_s10;
            default: w_next_state = c_s0;
        endcase
    end

    // A match completes only on a sampled edge that lands in S1011.
    assign w_hit = en && (w_next_state == c_s1011);

    always_comb begin
        w_cnt_next = r_match_cnt;
        if (clr_cnt) begin
            w_cnt_next = '0;
        end else if (w_hit && (r_match_cnt != c_cnt_max)) begin
            w_cnt_next = r_match_cnt + c_cnt_one;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_s0;
            r_match     <= 1'b0;
            r_match_cnt <= '0;
            r_cnt_sat   <= 1'b0;
        end else begin
            // Illegal codes recover even while en is low.
            if (en || w_illegal) begin
                r_state <= w_next_state;
            end
            r_match     <= w_hit;
            r_match_cnt <= w_cnt_next;
            r_cnt_sat   <= (w_cnt_next == c_cnt_max);
        end
    end

    assign match     = r_match;
    assign match_cnt = r_match_cnt;
    assign cnt_sat   = r_cnt_sat;
    assign state_o   = r_state;

endmodule
`default_nettype wire

// File: tb/tb_seq1011_detector.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq1011_detector
// Purpose  : Directed bench for seq1011_detector. Two instances (CNT_W=8 and
//            CNT_W=2) share one stimulus stream. Each stimulus step pushes the
//            hand-computed expected response into a queue; a monitor pops and
//            compares on the falling edge after every active clock edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq1011_detector;

    logic       clk;
    logic       rst;
    logic       en;
    logic       din;
    logic       clr_cnt;

    logic       match8;
    logic [7:0] match_cnt8;
    logic       cnt_sat8;
    logic [2:0] state8;

    logic       match2;
    logic [1:0] match_cnt2;
    logic       cnt_sat2;
    logic [2:0] state2;

    int         n_total;
    int         n_bad;

    // Expected response; cnt is the unsaturated match count since reset/clear.
    typedef struct {
        string tag;
        int    state;
        logic  match;
        int    cnt;
    } exp_t;

    exp_t q_exp[$];

    seq1011_detector #(.CNT_W(8)) u_dut8 (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .din       (din),
        .clr_cnt   (clr_cnt),
        .match     (match8),
        .match_cnt (match_cnt8),
        .cnt_sat   (cnt_sat8),
        .state_o   (state8)
    );

    seq1011_detector #(.CNT_W(2)) u_dut2 (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .din       (din),
        .clr_cnt   (clr_cnt),
        .match     (match2),
        .match_cnt (match_cnt2),
        .cnt_sat   (cnt_sat2),
        .state_o   (state2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        n_total++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Monitor: one output record per active edge, compared mid-cycle.
    always @(negedge clk) begin
        if (q_exp.size() > 0) begin
            exp_t e;
            int   c2;
            e  = q_exp.pop_front();
            c2 = (e.cnt > 3) ? 3 : e.cnt;
            check({e.tag, " state8"}, int'(state8), e.state);
            check({e.tag, " match8"}, int'(match8), int'(e.match));
            check({e.tag, " cnt8"},   int'(match_cnt8), e.cnt);
            check({e.tag, " sat8"},   int'(cnt_sat8), (e.cnt >= 255) ? 1 : 0);
            check({e.tag, " state2"}, int'(state2), e.state);
            check({e.tag, " match2"}, int'(match2), int'(e.match));
            check({e.tag, " cnt2"},   int'(match_cnt2), c2);
            check({e.tag, " sat2"},   int'(cnt_sat2), (e.cnt >= 3) ? 1 : 0);
        end
    end

    // Apply one edge of stimulus and queue the response expected after it.
    task automatic step(input string tag, input logic r, input logic e,
                        input logic d, input logic c,
                        input int es, input logic em, input int ec);
        exp_t x;
        rst     = r;
        en      = e;
        din     = d;
        clr_cnt = c;
        @(posedge clk);
        x.tag   = tag;
        x.state = es;
        x.match = em;
        x.cnt   = ec;
        q_exp.push_back(x);
        @(negedge clk);
    endtask

    task automatic gap(input string tag, input int es, input int ec);
        for (int k = 0; k < 3; k++) begin
            step(tag, 1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b0, es, 1'b0, ec);
        end
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
        rst     = 1'b1;
        en      = 1'b1;
        din     = 1'b1;
        clr_cnt = 1'b0;
        @(negedge clk);

        // Reset with en=1, din=1: reset dominates
        step("rst0", 1, 1, 1, 0, 0, 0, 0);
        step("rst1", 1, 1, 1, 1, 0, 0, 0);

        // Basic detect
        step("basic1", 0, 1, 1, 0, 1, 0, 0);
        step("basic2", 0, 1, 0, 0, 2, 0, 0);
        step("basic3", 0, 1, 1, 0, 3, 0, 0);
        step("basic4", 0, 1, 1, 0, 4, 1, 1);
        step("basic_hold", 0, 0, 1, 0, 4, 0, 1);

        // Overlap
        step("ovl_rst", 1, 1, 0, 0, 0, 0, 0);
        step("ovl1", 0, 1, 1, 0, 1, 0, 0);
        step("ovl2", 0, 1, 0, 0, 2, 0, 0);
        step("ovl3", 0, 1, 1, 0, 3, 0, 0);
        step("ovl4", 0, 1, 1, 0, 4, 1, 1);
        step("ovl5", 0, 1, 0, 0, 2, 0, 1);
        step("ovl6", 0, 1, 1, 0, 3, 0, 1);
        step("ovl7", 0, 1, 1, 0, 4, 1, 2);
        step("ovl_hold", 0, 1, 0, 0, 2, 0, 2);

        // Gating: en=0 for 3 cycles between valid bits, din random meanwhile
        step("gate_rst", 1, 0, 0, 0, 0, 0, 0);
        step("gate1", 0, 1, 1, 0, 1, 0, 0);
        gap("gap_a", 1, 0);
        step("gate2", 0, 1, 0, 0, 2, 0, 0);
        gap("gap_b", 2, 0);
        step("gate3", 0, 1, 1, 0, 3, 0, 0);
        gap("gap_c", 3, 0);
        step("gate4", 0, 1, 1, 0, 4, 1, 1);
        gap("gap_d", 4, 1);

        // Saturation: five back-to-back 1011 groups, then clear on a 6th match
        step("sat_rst", 1, 1, 1, 0, 0, 0, 0);
        for (int g = 1; g <= 5; g++) begin
            step("sat_a", 0, 1, 1, 0, 1, 0, g - 1);
            step("sat_b", 0, 1, 0, 0, 2, 0, g - 1);
            step("sat_c", 0, 1, 1, 0, 3, 0, g - 1);
            step("sat_d", 0, 1, 1, 0, 4, 1, g);
        end
        step("clr_a", 0, 1, 1, 0, 1, 0, 5);
        step("clr_b", 0, 1, 0, 0, 2, 0, 5);
        step("clr_c", 0, 1, 1, 0, 3, 0, 5);
        step("clr_d", 0, 1, 1, 1, 4, 1, 0);
        step("clr_after", 0, 1, 0, 0, 2, 0, 0);

        // Reset mid-sequence discards partial progress
        step("mid_rst0", 1, 1, 0, 0, 0, 0, 0);
        step("mid1", 0, 1, 1, 0, 1, 0, 0);
        step("mid2", 0, 1, 0, 0, 2, 0, 0);
        step("mid3", 0, 1, 1, 0, 3, 0, 0);
        step("mid_rst1", 1, 1, 1, 0, 0, 0, 0);
        step("mid4", 0, 1, 1, 0, 1, 0, 0);
        step("mid5", 0, 1, 0, 0, 2, 0, 0);
        step("mid6", 0, 1, 1, 0, 3, 0, 0);
        step("mid7", 0, 1, 1, 0, 4, 1, 1);

        // Let the monitor drain, then confirm nothing is left unchecked
        @(negedge clk);
        check("queue_drain", q_exp.size(), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
